spi_reg_master: RTL and testbench
=================================

SPI_REG_MASTER -- requirements
Module: spi_reg_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, clk cycles per SCLK half-period (legal 1..255).
REQ-002 SHALL have parameter CS_GAP, default 2, minimum clk cycles nCs stays high between frames (legal 1..255).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port cmd_valid  input  1  command request.
REQ-006 SHALL have port cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high on a clk edge.
REQ-007 SHALL have port cmd_wr  input  1  1 = register write, 0 = register read.
REQ-008 SHALL have port cmd_addr  input  7  register address.
REQ-009 SHALL have port cmd_wdata  input  8  write data (ignored for reads).
REQ-010 SHALL have port rd_data  output  8  last read result.
REQ-011 SHALL have port rd_valid  output  1  one-cycle pulse, rd_data updated.
REQ-012 SHALL have port nCs  output  1  SPI chip select, active-low.
REQ-013 SHALL have port sclk  output  1  SPI clock, mode 0 (idle low).
REQ-014 SHALL have port mosi  output  1  SPI master-out data.
REQ-015 SHALL have port miso  input  1  SPI slave-out data.

Function
REQ-016 Frame SHALL be 16 bits, MSB first: bit15 = cmd_wr, bits14:8 = cmd_addr, bits7:0 = cmd_wdata for writes, 0x00 for reads.
REQ-017 Command fields SHALL be registered on the accepting edge; later changes on cmd_* have no effect on the frame.
REQ-018 FSM states SHALL be IDLE, LEAD, SHIFT_LO, SHIFT_HI, TRAIL, GAP; cmd_ready SHALL be high only in IDLE.
REQ-019 IDLE -> LEAD on accept: nCs low and mosi = bit15 from the next cycle; LEAD lasts CLK_DIV cycles, sclk low.
REQ-020 Each bit SHALL be SHIFT_LO (sclk low, mosi stable, CLK_DIV cycles) then SHIFT_HI (sclk high, CLK_DIV cycles); LEAD serves as bit15 low phase.
REQ-021 mosi SHALL change only on the clk edge where sclk falls (or entering LEAD).
REQ-022 miso SHALL be sampled on the clk edge where sclk rises; 16 samples shifted MSB first.
REQ-023 After bit0 SHIFT_HI, TRAIL SHALL hold sclk low, nCs low for CLK_DIV cycles; then nCs high, GAP for CS_GAP cycles, then IDLE.
REQ-024 nCs low duration SHALL be exactly 33*CLK_DIV clk cycles (132 at default).
REQ-025 For reads, on the TRAIL->GAP edge rd_data SHALL take sampled bits 7:0 and rd_valid SHALL pulse one cycle; writes SHALL not pulse rd_valid nor change rd_data.
REQ-026 Back-to-back commands: a command held on cmd_valid SHALL be accepted on the first IDLE cycle after GAP.
REQ-027 Bit counter SHALL be 4 bits and the divider counter 8 bits; neither SHALL wrap mid-frame.

Reset
REQ-028 While rst high: nCs = 1, sclk = 0, mosi = 0, cmd_ready = 0, rd_valid = 0, rd_data = 0x00, state = IDLE, counters = 0.
REQ-029 rst asserted mid-frame SHALL abort immediately (asynchronously); no rd_valid for the aborted frame.
REQ-030 cmd_ready SHALL rise on the first clk edge after rst deasserts.

Configuration
REQ-031 Macro SPI_REG_MASTER_STATS_EN defined: output xfer_cnt (16 bits, reset 0) SHALL increment on each frame completing TRAIL, saturating at 0xFFFF; aborted frames not counted.
REQ-032 Macro SPI_REG_MASTER_STATS_EN undefined: xfer_cnt port and counter SHALL not exist; all other behaviour identical.

Verification
REQ-033 Write wr=1 addr=0x12 wdata=0xA5, CLK_DIV=4 -> mosi bits 0x92A5 MSB first, nCs low 132 cycles, no rd_valid.
REQ-034 Read addr=0x05, slave model drives miso byte 0x3C in data phase -> mosi 0x0500, rd_data=0x3C, single rd_valid pulse at nCs rise.
REQ-035 cmd_valid held high for two writes -> nCs high exactly CS_GAP=2 cycles between frames, second accepted first IDLE cycle.
REQ-036 rst pulse at bit 8 of a read -> nCs=1, sclk=0 same cycle; no rd_valid; next read completes correctly.
REQ-037 CLK_DIV=1 write 0xFF at 0x7F -> sclk period 2 clk cycles, frame 0xFFFF, nCs low 33 cycles.
REQ-038 With SPI_REG_MASTER_STATS_EN, 3 frames plus one reset-aborted frame -> xfer_cnt=3 (counter cleared by reset, then counts only post-reset completions).

Source files
------------

// File: rtl/spi_reg_master.sv
// spi_reg_master: SPI mode-0 register-access master.
// Sends one 16-bit frame per command: {wr, addr[6:0], wdata or 0x00}, MSB
// first. Reads return the last 8 bits shifted in on miso.
// Optional build macro SPI_REG_MASTER_STATS_EN adds the xfer_cnt output,
// a saturating count of frames that ran to completion.
`timescale 1ns/1ps
module spi_reg_master #(
   parameter int CLK_DIV = 4,   // clk cycles per SCLK half-period (1..255)
   parameter int CS_GAP  = 2    // clk cycles nCs stays high between frames (1..255)
) (
   input  logic        clk,
   input  logic        rst,
   // Handshake: a command transfers on a rising clk edge where cmd_valid and
   // cmd_ready are both high. cmd_ready never depends on cmd_valid, and the
   // command fields are captured on that edge only.
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_wr,
   input  logic [6:0]  cmd_addr,
   input  logic [7:0]  cmd_wdata,
   output logic [7:0]  rd_data,
   output logic        rd_valid,
   output logic        nCs,
   output logic        sclk,
   output logic        mosi,
   input  logic        miso,
`ifdef SPI_REG_MASTER_STATS_EN
   output logic [15:0] xfer_cnt,
`endif
   output logic [2:0]  fsm_state
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      LEAD     = 3'd1,
      SHIFT_LO = 3'd2,
      SHIFT_HI = 3'd3,
      TRAIL    = 3'd4,
      GAP      = 3'd5
   } state_t;

   // Last divider value of a half-period.
   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
   // The IDLE cycle in which the next command is accepted is itself an nCs-high
   // cycle, so the GAP state covers CS_GAP-1 cycles and is skipped when CS_GAP=1.
   localparam logic [7:0] GAP_LAST = (CS_GAP > 1) ? 8'(CS_GAP - 2) : 8'd0;

   state_t      state, state_nxt;
   logic [7:0]  div_cnt;
   logic [3:0]  bit_cnt;
   logic [15:0] tx_sr;
   logic [15:0] rx_sr;
   logic        is_rd;
   logic        accept;
   logic        rise;    // edge where sclk goes high: sample miso
   logic        fall;    // edge where sclk goes low between bits: advance mosi
   logic        done;    // last TRAIL cycle: frame completes on this edge

   assign accept    = (state == IDLE) && cmd_ready && cmd_valid;
   assign fsm_state = state;

   // Next-state decode and per-edge strobes.
   always_comb begin
      state_nxt = state;
      rise      = 1'b0;
      fall      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (accept) state_nxt = LEAD;
         end
         LEAD: begin
            if (div_cnt == DIV_LAST) begin
               state_nxt = SHIFT_HI;
               rise      = 1'b1;
            end
         end
         SHIFT_LO: begin
            if (div_cnt == DIV_LAST) begin
               state_nxt = SHIFT_HI;
               rise      = 1'b1;
            end
         end
         SHIFT_HI: begin
            if (div_cnt == DIV_LAST) begin
               if (bit_cnt == 4'd0) begin
                  state_nxt = TRAIL;
               end else begin
                  state_nxt = SHIFT_LO;
                  fall      = 1'b1;
               end
            end
         end
         TRAIL: begin
            if (div_cnt == DIV_LAST) begin
               state_nxt = (CS_GAP > 1) ? GAP : IDLE;
               done      = 1'b1;
            end
         end
         GAP: begin
            if (div_cnt == GAP_LAST) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register and divider: the divider restarts on every state change.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         div_cnt <= 8'd0;
      end else begin
         state <= state_nxt;
         if ((state_nxt != state) || (state == IDLE)) div_cnt <= 8'd0;
         else                                         div_cnt <= div_cnt + 8'd1;
      end
   end

   // Frame datapath: capture the command, shift mosi out and miso in.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt <= 4'd0;
         tx_sr   <= 16'h0000;
         rx_sr   <= 16'h0000;
         is_rd   <= 1'b0;
         mosi    <= 1'b0;
      end else begin
         if (accept) begin
            bit_cnt <= 4'd15;
            tx_sr   <= {cmd_wr, cmd_addr, (cmd_wr ? cmd_wdata : 8'h00)};
            is_rd   <= ~cmd_wr;
            mosi    <= cmd_wr;
         end else if (fall) begin
            bit_cnt <= bit_cnt - 4'd1;
            tx_sr   <= {tx_sr[14:0], 1'b0};
            mosi    <= tx_sr[14];
         end
         if (rise) rx_sr <= {rx_sr[14:0], miso};
      end
   end

   // Registered SPI pins and handshake, decoded from the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         nCs       <= 1'b1;
         sclk      <= 1'b0;
         cmd_ready <= 1'b0;
      end else begin
         nCs       <= !((state_nxt == LEAD) || (state_nxt == SHIFT_LO) ||
                        (state_nxt == SHIFT_HI) || (state_nxt == TRAIL));
         sclk      <= (state_nxt == SHIFT_HI);
         cmd_ready <= (state_nxt == IDLE);
      end
   end

   // Read result: published with a one-cycle pulse as nCs rises.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data  <= 8'h00;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= done && is_rd;
         if (done && is_rd) rd_data <= rx_sr[7:0];
      end
   end

`ifdef SPI_REG_MASTER_STATS_EN
   // Completed-frame counter, saturating; aborted frames never reach done.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                              xfer_cnt <= 16'h0000;
      else if (done && xfer_cnt != 16'hFFFF) xfer_cnt <= xfer_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_spi_reg_master.sv
// tb_spi_reg_master: bench for spi_reg_master (CLK_DIV=4/CS_GAP=2 instance
// plus a CLK_DIV=1/CS_GAP=1 instance).
`timescale 1ns/1ps
module tb_spi_reg_master;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // ---------------- instance A (defaults) ----------------
   logic       a_cmd_valid, a_cmd_ready, a_cmd_wr;
   logic [6:0] a_cmd_addr;
   logic [7:0] a_cmd_wdata, a_rd_data;
   logic       a_rd_valid, a_ncs, a_sclk, a_mosi, a_miso;
   logic [2:0] a_state;
`ifdef SPI_REG_MASTER_STATS_EN
   logic [15:0] a_xfer_cnt, b_xfer_cnt;
`endif

   spi_reg_master #(.CLK_DIV(4), .CS_GAP(2)) u_dut_a (
      .clk(clk), .rst(rst), .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready),
      .cmd_wr(a_cmd_wr), .cmd_addr(a_cmd_addr), .cmd_wdata(a_cmd_wdata),
      .rd_data(a_rd_data), .rd_valid(a_rd_valid), .nCs(a_ncs), .sclk(a_sclk),
      .mosi(a_mosi), .miso(a_miso),
`ifdef SPI_REG_MASTER_STATS_EN
      .xfer_cnt(a_xfer_cnt),
`endif
      .fsm_state(a_state)
   );

   // ---------------- instance B (fastest clock) ----------------
   logic       b_cmd_valid, b_cmd_ready, b_cmd_wr;
   logic [6:0] b_cmd_addr;
   logic [7:0] b_cmd_wdata, b_rd_data;
   logic       b_rd_valid, b_ncs, b_sclk, b_mosi, b_miso;
   logic [2:0] b_state;
   assign b_miso = 1'b0;

   spi_reg_master #(.CLK_DIV(1), .CS_GAP(1)) u_dut_b (
      .clk(clk), .rst(rst), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
      .cmd_wr(b_cmd_wr), .cmd_addr(b_cmd_addr), .cmd_wdata(b_cmd_wdata),
      .rd_data(b_rd_data), .rd_valid(b_rd_valid), .nCs(b_ncs), .sclk(b_sclk),
      .mosi(b_mosi), .miso(b_miso),
`ifdef SPI_REG_MASTER_STATS_EN
      .xfer_cnt(b_xfer_cnt),
`endif
      .fsm_state(b_state)
   );

   // ---------------- scoreboard ----------------
   logic [15:0] exp_q[$];      // expected mosi frames, pushed at command issue
   logic [7:0]  rd_exp_q[$];   // expected read bytes, pushed at command issue
   logic [15:0] a_got_q[$];    // frames captured by the slave model
   logic [7:0]  exp_rd_last = 8'h00;
   int          exp_xfer = 0;

   // ---------------- slave model A ----------------
   logic [15:0] a_cap = 16'h0000;
   int          a_bits = 0;
   logic [15:0] a_slv_word = 16'h0000;
   logic [3:0]  a_idx;
   assign a_idx  = 4'd15 - 4'(a_bits);
   assign a_miso = a_slv_word[a_idx];

   // mosi captured on sclk rise; cleared as nCs falls
   always @(negedge a_ncs or posedge a_sclk) begin
      if (a_sclk) begin
         a_cap  <= {a_cap[14:0], a_mosi};
         a_bits <= a_bits + 1;
      end else begin
         a_cap  <= 16'h0000;
         a_bits <= 0;
      end
   end

   int   a_low_run = 0, a_high_run = 0, a_last_low = 0, a_last_high = 0;
   int   a_done = 0, a_rdv = 0;
   logic [7:0] a_last_rd = 8'h00;
   logic a_rdv_at_rise = 1'b0;
   logic a_prev_ncs = 1'b1;

   // nCs timing / rd_valid monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (!a_ncs) begin
         if (a_prev_ncs) a_last_high = a_high_run;
         a_low_run++;
         a_high_run = 0;
      end else begin
         if (!a_prev_ncs) begin
            a_last_low    = a_low_run;
            a_rdv_at_rise = a_rd_valid;
            a_got_q.push_back(a_cap);
            a_done++;
         end
         a_low_run = 0;
         a_high_run++;
      end
      if (a_rd_valid) begin
         a_rdv++;
         a_last_rd = a_rd_data;
      end
      a_prev_ncs = a_ncs;
   end

   // ---------------- slave model B ----------------
   logic [15:0] b_cap = 16'h0000;
   always @(negedge b_ncs or posedge b_sclk) begin
      if (b_sclk) b_cap <= {b_cap[14:0], b_mosi};
      else        b_cap <= 16'h0000;
   end

   int   b_low_run = 0, b_hi_cnt = 0, b_hi_run = 0, b_hi_max = 0;
   int   b_last_low = 0, b_last_hi = 0, b_last_himax = 0, b_done = 0, b_rdv = 0;
   logic [15:0] b_last_cap = 16'h0000;
   logic b_prev_ncs = 1'b1;

   always @(negedge clk) begin
      if (!b_ncs) begin
         b_low_run++;
         if (b_sclk) begin
            b_hi_cnt++;
            b_hi_run++;
            if (b_hi_run > b_hi_max) b_hi_max = b_hi_run;
         end else begin
            b_hi_run = 0;
         end
      end else begin
         if (!b_prev_ncs) begin
            b_last_low   = b_low_run;
            b_last_hi    = b_hi_cnt;
            b_last_himax = b_hi_max;
            b_last_cap   = b_cap;
            b_done++;
         end
         b_low_run = 0; b_hi_cnt = 0; b_hi_run = 0; b_hi_max = 0;
      end
      if (b_rd_valid) b_rdv++;
      b_prev_ncs = b_ncs;
   end

   // ---------------- driver tasks ----------------
   task automatic send_a(input logic wr, input logic [6:0] addr, input logic [7:0] wd,
                         output bit ok);
      @(negedge clk);
      for (int i = 0; i < 400 && !a_cmd_ready; i++) @(negedge clk);
      ok          = a_cmd_ready;
      a_cmd_valid = 1'b1;
      a_cmd_wr    = wr;
      a_cmd_addr  = addr;
      a_cmd_wdata = wd;
      exp_q.push_back({wr, addr, (wr ? wd : 8'h00)});
      @(posedge clk);
      #1;
      a_cmd_valid = 1'b0;
      a_cmd_wr    = ~wr;       // later changes must not reach the frame
      a_cmd_addr  = ~addr;
      a_cmd_wdata = ~wd;
   endtask

   task automatic wait_done_a(input int target, output bit ok);
      for (int i = 0; i < 3000 && a_done < target; i++) @(posedge clk);
      ok = (a_done >= target);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      a_cmd_valid = 0; a_cmd_wr = 0; a_cmd_addr = '0; a_cmd_wdata = '0;
      b_cmd_valid = 0; b_cmd_wr = 0; b_cmd_addr = '0; b_cmd_wdata = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (a_ncs !== 1'b1)       begin failures++; $display("FAIL reset_ncs got=%b exp=1", a_ncs); end
      checks++; if (a_sclk !== 1'b0)      begin failures++; $display("FAIL reset_sclk got=%b exp=0", a_sclk); end
      checks++; if (a_mosi !== 1'b0)      begin failures++; $display("FAIL reset_mosi got=%b exp=0", a_mosi); end
      checks++; if (a_cmd_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", a_cmd_ready); end
      checks++; if (a_rd_valid !== 1'b0)  begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", a_rd_valid); end
      checks++; if (a_rd_data !== 8'h00)  begin failures++; $display("FAIL reset_rd_data got=%h exp=00", a_rd_data); end
      checks++; if (a_state !== 3'd0)     begin failures++; $display("FAIL reset_state got=%0d exp=0", a_state); end
      checks++; if (b_ncs !== 1'b1 || b_cmd_ready !== 1'b0) begin failures++; $display("FAIL reset_b got=ncs%b rdy%b exp=ncs1 rdy0", b_ncs, b_cmd_ready); end
`ifdef SPI_REG_MASTER_STATS_EN
      checks++; if (a_xfer_cnt !== 16'h0) begin failures++; $display("FAIL reset_xfer got=%0d exp=0", a_xfer_cnt); end
`endif
      rst = 1'b0;
      @(negedge clk);
      checks++; if (a_cmd_ready !== 1'b1) begin failures++; $display("FAIL ready_after_reset got=%b exp=1", a_cmd_ready); end
   endtask

   task automatic test_write_cmd(input logic [6:0] addr, input logic [7:0] wd);
      int d0, rv0; bit ok; logic [15:0] got, exp;
      d0 = a_done; rv0 = a_rdv;
      send_a(1'b1, addr, wd, ok);
      checks++; if (!ok) begin failures++; $display("FAIL wr_ready_wait got=0 exp=1"); end
      wait_done_a(d0 + 1, ok);
      checks++; if (!ok) begin failures++; $display("FAIL wr_frame_timeout got=%0d exp=%0d", a_done, d0 + 1); end
      repeat (2) @(posedge clk);
      if (a_got_q.size() == 0 || exp_q.size() == 0) begin
         checks++; failures++; $display("FAIL wr_frame_missing got=%0d exp=%0d", a_got_q.size(), exp_q.size());
      end else begin
         got = a_got_q.pop_front(); exp = exp_q.pop_front();
         checks++; if (got !== exp) begin failures++; $display("FAIL wr_frame got=%h exp=%h", got, exp); end
      end
      checks++; if (a_last_low != 132) begin failures++; $display("FAIL wr_ncs_low got=%0d exp=132", a_last_low); end
      checks++; if (a_bits != 16)      begin failures++; $display("FAIL wr_bits got=%0d exp=16", a_bits); end
      checks++; if (a_rdv != rv0)      begin failures++; $display("FAIL wr_no_rd_valid got=%0d exp=%0d", a_rdv, rv0); end
      checks++; if (a_rd_data !== exp_rd_last) begin failures++; $display("FAIL wr_rd_data_kept got=%h exp=%h", a_rd_data, exp_rd_last); end
      exp_xfer++;
   endtask

   task automatic test_read_cmd(input logic [6:0] addr, input logic [7:0] slv_byte);
      int d0, rv0; bit ok; logic [15:0] got, exp; logic [7:0] rexp;
      d0 = a_done; rv0 = a_rdv;
      a_slv_word = {8'hC3, slv_byte};
      rd_exp_q.push_back(slv_byte);
      send_a(1'b0, addr, 8'hEE, ok);
      checks++; if (!ok) begin failures++; $display("FAIL rd_ready_wait got=0 exp=1"); end
      wait_done_a(d0 + 1, ok);
      checks++; if (!ok) begin failures++; $display("FAIL rd_frame_timeout got=%0d exp=%0d", a_done, d0 + 1); end
      repeat (4) @(posedge clk);
      if (a_got_q.size() == 0 || exp_q.size() == 0) begin
         checks++; failures++; $display("FAIL rd_frame_missing got=%0d exp=%0d", a_got_q.size(), exp_q.size());
      end else begin
         got = a_got_q.pop_front(); exp = exp_q.pop_front();
         checks++; if (got !== exp) begin failures++; $display("FAIL rd_frame got=%h exp=%h", got, exp); end
      end
      checks++; if (a_last_low != 132)   begin failures++; $display("FAIL rd_ncs_low got=%0d exp=132", a_last_low); end
      checks++; if (a_rdv != rv0 + 1)    begin failures++; $display("FAIL rd_valid_pulses got=%0d exp=%0d", a_rdv - rv0, 1); end
      checks++; if (a_rdv_at_rise !== 1'b1) begin failures++; $display("FAIL rd_valid_at_ncs_rise got=%b exp=1", a_rdv_at_rise); end
      rexp = rd_exp_q.pop_front();
      checks++; if (a_last_rd !== rexp)  begin failures++; $display("FAIL rd_data_pulse got=%h exp=%h", a_last_rd, rexp); end
      checks++; if (a_rd_data !== rexp)  begin failures++; $display("FAIL rd_data_hold got=%h exp=%h", a_rd_data, rexp); end
      exp_rd_last = rexp;
      exp_xfer++;
   endtask

   task automatic test_write();
      test_write_cmd(7'h12, 8'hA5);   // frame 0x92A5
   endtask

   task automatic test_read();
      test_read_cmd(7'h05, 8'h3C);    // frame 0x0500, returns 0x3C
   endtask

   task automatic test_back_to_back();
      int d0; bit ok; logic [15:0] got, exp;
      d0 = a_done;
      @(negedge clk);
      for (int i = 0; i < 400 && !a_cmd_ready; i++) @(negedge clk);
      a_cmd_valid = 1'b1; a_cmd_wr = 1'b1; a_cmd_addr = 7'h21; a_cmd_wdata = 8'h5A;
      exp_q.push_back(16'h A15A);
      @(posedge clk);
      #1;
      a_cmd_addr = 7'h6E; a_cmd_wdata = 8'hC7;     // held valid for the second frame
      exp_q.push_back(16'hEEC7);
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (a_cmd_ready) begin ok = 1'b1; break; end
      end
      @(posedge clk);
      #1;
      a_cmd_valid = 1'b0; a_cmd_addr = 7'h00; a_cmd_wdata = 8'h00;
      checks++; if (!ok) begin failures++; $display("FAIL b2b_second_ready got=0 exp=1"); end
      wait_done_a(d0 + 2, ok);
      checks++; if (!ok) begin failures++; $display("FAIL b2b_timeout got=%0d exp=%0d", a_done, d0 + 2); end
      repeat (2) @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (a_got_q.size() == 0 || exp_q.size() == 0) begin
            checks++; failures++; $display("FAIL b2b_frame_missing got=%0d exp=%0d", a_got_q.size(), exp_q.size());
         end else begin
            got = a_got_q.pop_front(); exp = exp_q.pop_front();
            checks++; if (got !== exp) begin failures++; $display("FAIL b2b_frame%0d got=%h exp=%h", k, got, exp); end
         end
      end
      checks++; if (a_last_high != 2)  begin failures++; $display("FAIL b2b_ncs_gap got=%0d exp=2", a_last_high); end
      checks++; if (a_last_low != 132) begin failures++; $display("FAIL b2b_ncs_low got=%0d exp=132", a_last_low); end
      exp_xfer += 2;
   endtask

   task automatic test_random();
      for (int n = 0; n < 4; n++) begin
         if ($urandom_range(0, 1) == 1)
            test_write_cmd(7'($urandom_range(0, 127)), 8'($urandom_range(0, 255)));
         else
            test_read_cmd(7'($urandom_range(0, 127)), 8'($urandom_range(0, 255)));
      end
   endtask

   task automatic test_abort();
      int rv0; bit ok;
      rv0 = a_rdv;
      a_slv_word = {8'hC3, 8'h5A};
      send_a(1'b0, 7'h33, 8'h00, ok);
      checks++; if (!ok) begin failures++; $display("FAIL abort_ready_wait got=0 exp=1"); end
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (a_bits == 8) begin ok = 1'b1; break; end
      end
      checks++; if (!ok) begin failures++; $display("FAIL abort_reach_bit8 got=%0d exp=8", a_bits); end
      #2;
      rst = 1'b1;
      #1;
      checks++; if (a_ncs !== 1'b1)  begin failures++; $display("FAIL abort_ncs got=%b exp=1", a_ncs); end
      checks++; if (a_sclk !== 1'b0) begin failures++; $display("FAIL abort_sclk got=%b exp=0", a_sclk); end
      checks++; if (a_state !== 3'd0) begin failures++; $display("FAIL abort_state got=%0d exp=0", a_state); end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      checks++; if (a_rdv != rv0)       begin failures++; $display("FAIL abort_no_rd_valid got=%0d exp=%0d", a_rdv, rv0); end
      checks++; if (a_rd_data !== 8'h00) begin failures++; $display("FAIL abort_rd_data got=%h exp=00", a_rd_data); end
      exp_rd_last = 8'h00;
      exp_xfer    = 0;
`ifdef SPI_REG_MASTER_STATS_EN
      checks++; if (a_xfer_cnt !== 16'h0) begin failures++; $display("FAIL abort_xfer_clear got=%0d exp=0", a_xfer_cnt); end
`endif
      exp_q.delete();
      rd_exp_q.delete();
      a_got_q.delete();
      test_read_cmd(7'h41, 8'h81);
   endtask

   task automatic test_clkdiv1();
      logic [6:0]  addrs[2];
      logic [7:0]  datas[2];
      logic [15:0] exp;
      int d0; bit ok;
      addrs[0] = 7'h7F; datas[0] = 8'hFF;
      addrs[1] = 7'h2A; datas[1] = 8'h00;
      for (int k = 0; k < 2; k++) begin
         d0 = b_done;
         @(negedge clk);
         for (int i = 0; i < 400 && !b_cmd_ready; i++) @(negedge clk);
         b_cmd_valid = 1'b1; b_cmd_wr = 1'b1; b_cmd_addr = addrs[k]; b_cmd_wdata = datas[k];
         exp = {1'b1, addrs[k], datas[k]};
         @(posedge clk);
         #1;
         b_cmd_valid = 1'b0; b_cmd_wr = 1'b0; b_cmd_addr = ~addrs[k]; b_cmd_wdata = ~datas[k];
         for (int i = 0; i < 500 && b_done == d0; i++) @(posedge clk);
         checks++; if (b_done == d0) begin failures++; $display("FAIL div1_timeout got=%0d exp=%0d", b_done, d0 + 1); end
         checks++; if (b_last_cap !== exp) begin failures++; $display("FAIL div1_frame got=%h exp=%h", b_last_cap, exp); end
         checks++; if (b_last_low != 33)   begin failures++; $display("FAIL div1_ncs_low got=%0d exp=33", b_last_low); end
         checks++; if (b_last_hi != 16 || b_last_himax != 1) begin failures++; $display("FAIL div1_sclk got=hi%0d run%0d exp=hi16 run1", b_last_hi, b_last_himax); end
         checks++; if (b_rdv != 0 || b_rd_data !== 8'h00) begin failures++; $display("FAIL div1_no_read got=%0d/%h exp=0/00", b_rdv, b_rd_data); end
      end
   endtask

   task automatic test_stats();
      test_write_cmd(7'h0C, 8'h3E);
      test_write_cmd(7'h70, 8'h01);
`ifdef SPI_REG_MASTER_STATS_EN
      checks++; if (a_xfer_cnt != 16'(exp_xfer)) begin failures++; $display("FAIL stats_xfer got=%0d exp=%0d", a_xfer_cnt, exp_xfer); end
      checks++; if (b_xfer_cnt != 16'd2) begin failures++; $display("FAIL stats_xfer_b got=%0d exp=2", b_xfer_cnt); end
`endif
      checks++; if (b_state !== 3'd0) begin failures++; $display("FAIL b_idle_state got=%0d exp=0", b_state); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_write();
      test_read();
      test_back_to_back();
      test_random();
      test_abort();
      test_clkdiv1();
      test_stats();
      checks++; if (exp_q.size() != 0 || a_got_q.size() != 0) begin failures++; $display("FAIL scoreboard_leftover got=%0d/%0d exp=0/0", exp_q.size(), a_got_q.size()); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
